// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Assembles the glyph column stream into a double-buffered 16x4 frame and scans a
//   16-column x 4-row LED matrix, one column at a time, with anti-ghost blanking at the
//   start of every column. The back bank is written while the front bank is displayed.
//   The banks swap only at the 15->0 column wrap, and only once every back column has
//   been written, so a displayed frame is never torn.
//
//   Optional feature: define LED_MATRIX_PWM_EN to enable 8-level PWM of the row drive
//   during the DRIVE phase. Without it, brightness is ignored.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active low
//   col_valid   col_idx/col_rows valid this cycle
//   col_idx     column index 0..15 of incoming data
//   col_rows    row bits for that column, bit3 = top row
//   brightness  PWM level, 0 = 1/8 .. 7 = 8/8 (PWM build only)
//   col_addr    column currently driven (to external 4:16 decoder)
//   row_drive   row outputs for col_addr
//   frame_sync  1-cycle pulse on each column wrap 15->0
//   swap_done   1-cycle pulse when the buffers swap
module led_matrix_scanner #(
  parameter int unsigned DWELL_CYCLES   = 64,
  parameter int unsigned BLANK_CYCLES   = 4,
  parameter bit          ROW_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       col_valid,
  input  logic [3:0] col_idx,
  input  logic [3:0] col_rows,
  input  logic [2:0] brightness,
  output logic [3:0] col_addr,
  output logic [3:0] row_drive,
  output logic       frame_sync,
  output logic       swap_done
);

  localparam int unsigned PW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [PW-1:0] PhaseLast  = PW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] PhaseBlank = PW'(BLANK_CYCLES);
  localparam logic [3:0]    RowOff     = ROW_ACTIVE_LOW ? 4'hF : 4'h0;

  localparam logic [0:0] StBlank = 1'b0;
  localparam logic [0:0] StDrive = 1'b1;

  logic [1:0][15:0][3:0] bank_q, bank_d;
  logic                  front_q, front_d;
  logic [15:0]           mask_q, mask_d;
  logic                  pending_q, pending_d;
  logic [3:0]            col_q, col_d;
  logic [0:0]            state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [3:0]            row_drive_q, row_drive_d;
  logic                  frame_sync_q, swap_done_q;
  logic                  col_last, wrap, do_swap, rows_on;
  logic [3:0]            rows;

`ifdef LED_MATRIX_PWM_EN
  logic [2:0] pwm_cnt_q, pwm_cnt_d;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  always_comb begin
    col_last = (phase_q == PhaseLast);
    wrap     = col_last && (col_q == 4'hF);
    phase_d  = col_last ? '0 : phase_q + PW'(1);
    col_d    = col_last ? col_q + 4'd1 : col_q;
    state_d  = (phase_d < PhaseBlank) ? StBlank : StDrive;

    // A mask that fills just before the wrap still swaps on that wrap.
    do_swap   = wrap && (pending_q || (&mask_q));
    front_d   = front_q ^ do_swap;
    pending_d = do_swap ? 1'b0 : (pending_q | (&mask_q));

    // Writes target the back bank as seen after this edge, so a write on the
    // swap edge lands in the new back bank.
    bank_d = bank_q;
    mask_d = do_swap ? 16'h0000 : mask_q;
    if (col_valid) begin
      bank_d[~front_d][col_idx] = col_rows;
      mask_d[col_idx]           = 1'b1;
    end

`ifdef LED_MATRIX_PWM_EN
    if (state_d == StDrive) begin
      pwm_cnt_d = (state_q == StBlank) ? 3'd0 : pwm_cnt_q + 3'd1;
    end else begin
      pwm_cnt_d = 3'd0;
    end
    rows_on = (state_d == StDrive) && (pwm_cnt_d <= brightness);
`else
    rows_on = (state_d == StDrive);
`endif

    // Row output is computed from next-cycle state so it lines up with col_addr.
    rows        = rows_on ? bank_q[front_d][col_d] : 4'h0;
    row_drive_d = ROW_ACTIVE_LOW ? ~rows : rows;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q       <= '0;
      front_q      <= 1'b0;
      mask_q       <= 16'h0000;
      pending_q    <= 1'b0;
      col_q        <= 4'h0;
      state_q      <= StBlank;
      phase_q      <= '0;
      row_drive_q  <= RowOff;
      frame_sync_q <= 1'b0;
      swap_done_q  <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      front_q      <= front_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      col_q        <= col_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      row_drive_q  <= row_drive_d;
      frame_sync_q <= wrap;
      swap_done_q  <= do_swap;
    end
  end

`ifdef LED_MATRIX_PWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= 3'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

  assign col_addr   = col_q;
  assign row_drive  = row_drive_q;
  assign frame_sync = frame_sync_q;
  assign swap_done  = swap_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with DWELL_CYCLES=8, BLANK_CYCLES=2.
// cyc counts clock edges since reset release; one frame is 128 cycles.
module tb_led_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       col_valid;
  logic [3:0] col_idx;
  logic [3:0] col_rows;
  logic [2:0] brightness;
  logic [3:0] col_addr;
  logic [3:0] row_drive;
  logic       frame_sync;
  logic       swap_done;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  led_matrix_scanner #(
    .DWELL_CYCLES  (8),
    .BLANK_CYCLES  (2),
    .ROW_ACTIVE_LOW(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_valid (col_valid),
    .col_idx   (col_idx),
    .col_rows  (col_rows),
    .brightness(brightness),
    .col_addr  (col_addr),
    .row_drive (row_drive),
    .frame_sync(frame_sync),
    .swap_done (swap_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  logic [3:0] pwm_b1 [8];
  logic [3:0] full_b7 [8];
  int sw_cnt, fs_cnt;
  logic [3:0] row_or;

  initial begin
    full_b7 = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
`ifdef LED_MATRIX_PWM_EN
    pwm_b1  = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
`else
    pwm_b1  = full_b7;
`endif
    rst_n = 1'b0; col_valid = 1'b0; col_idx = 4'h0; col_rows = 4'h0; brightness = 3'd7;

    // 1. Reset values and first column change.
    #12;
    check("rst_col_addr", 16'(col_addr), 16'h0);
    check("rst_row_drive", 16'(row_drive), 16'h0);
    check("rst_frame_sync", 16'(frame_sync), 16'h0);
    check("rst_swap_done", 16'(swap_done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    goto(7);
    check("col_before_8", 16'(col_addr), 16'h0);
    step();
    check("col_at_8", 16'(col_addr), 16'h1);

    // 2. Full frame write, swap at the next wrap, column 5 timing.
    goto(10);
    for (int i = 0; i < 16; i++) begin
      col_valid = 1'b1; col_idx = 4'(i); col_rows = 4'(i);
      step();
    end
    col_valid = 1'b0;
    goto(127);
    check("swap_before_wrap", 16'(swap_done), 16'h0);
    check("fsync_before_wrap", 16'(frame_sync), 16'h0);
    step();
    check("swap_at_wrap", 16'(swap_done), 16'h1);
    check("fsync_at_wrap", 16'(frame_sync), 16'h1);
    check("col_at_wrap", 16'(col_addr), 16'h0);
    step();
    check("swap_one_cycle", 16'(swap_done), 16'h0);
    check("fsync_one_cycle", 16'(frame_sync), 16'h0);
    goto(128 + 40);
    for (int k = 0; k < 8; k++) begin
      check("col5_addr", 16'(col_addr), 16'h5);
      check("col5_rows", 16'(row_drive), (k < 2) ? 16'h0 : 16'h5);
      step();
    end

    // 3. Incomplete back bank: no swap for three frames, old frame persists.
    goto(130);
    for (int i = 0; i < 15; i++) begin
      col_valid = 1'b1; col_idx = 4'(i); col_rows = 4'hF;
      step();
    end
    col_valid = 1'b0;
    sw_cnt = 0; fs_cnt = 0;
    while (cyc < 588) begin
      step();
      sw_cnt += int'(swap_done);
      fs_cnt += int'(frame_sync);
    end
    check("old_frame_col9", 16'(row_drive), 16'h9);
    while (cyc < 600) begin
      step();
      sw_cnt += int'(swap_done);
      fs_cnt += int'(frame_sync);
    end
    check("no_swap_count", 16'(sw_cnt), 16'h0);
    check("fsync_count", 16'(fs_cnt), 16'h3);

    // 5. Complete the bank, then write col 3 exactly on the swap edge.
    col_valid = 1'b1; col_idx = 4'hF; col_rows = 4'hF;
    step();
    col_valid = 1'b0;
    goto(639);
    col_valid = 1'b1; col_idx = 4'h3; col_rows = 4'h6;
    step();
    col_valid = 1'b0;
    check("swap_edge_done", 16'(swap_done), 16'h1);
    check("swap_edge_mask", dut.mask_q, 16'h0008);
    goto(640 + 24 + 4);
    check("new_front_col3", 16'(row_drive), 16'hF);
    goto(640 + 127);
    check("new_front_col15", 16'(row_drive), 16'hF);

    // 4. Brightness 1 on column 5, brightness 7 on column 6.
    goto(800);
    brightness = 3'd1;
    goto(808);
    for (int k = 0; k < 8; k++) begin
      check("bright1_rows", 16'(row_drive), 16'(pwm_b1[k]));
      if (k == 7) brightness = 3'd7;
      step();
    end
    for (int k = 0; k < 8; k++) begin
      check("bright7_rows", 16'(row_drive), 16'(full_b7[k]));
      step();
    end

    // 6. Asynchronous reset mid-DRIVE with row_drive=4'hA.
    goto(830);
    for (int i = 0; i < 16; i++) begin
      col_valid = 1'b1; col_idx = 4'(i); col_rows = 4'hA;
      step();
    end
    col_valid = 1'b0;
    goto(917);
    check("pre_rst_rows", 16'(row_drive), 16'hA);
    check("pre_rst_col", 16'(col_addr), 16'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rows", 16'(row_drive), 16'h0);
    check("async_rst_col", 16'(col_addr), 16'h0);

    // 3b. After reset, cols 0..14 only: front stays all zeros, never swaps.
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    goto(2);
    for (int i = 0; i < 15; i++) begin
      col_valid = 1'b1; col_idx = 4'(i); col_rows = 4'hF;
      step();
    end
    col_valid = 1'b0;
    sw_cnt = 0; fs_cnt = 0; row_or = 4'h0;
    while (cyc < 400) begin
      step();
      sw_cnt += int'(swap_done);
      fs_cnt += int'(frame_sync);
      row_or |= row_drive;
    end
    check("fresh_no_swap", 16'(sw_cnt), 16'h0);
    check("fresh_fsync", 16'(fs_cnt), 16'h3);
    check("fresh_rows_zero", 16'(row_or), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
